pulse_width_meter: RTL and testbench

- Measuring counterpart of the one-shot interval timer: the timer turns a programmed length into a pulse; this block turns an observed pulse into a length.
- Measures the high time of an external level signal, such as a switch-panel or test-fixture response, in selectable units of us, ms or s.
- Reports the result as a 16-bit count with a one-cycle valid strobe.
- Sits beside the timer in the switch-control subsystem and uses the same prescaler constants.

---
 rtl/pulse_width_meter.sv | 196 +++++++++++++++++++
 tb/tb_pulse_width_meter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_width_meter.sv
// Measures the high time of i_sig_in in us/ms/s units and reports a saturating 16-bit length.
// Define PULSE_WIDTH_METER_CONT_EN to re-arm automatically after every result (continuous mode).
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_IDLE      | waiting for i_arm with a legal unit
// S_WAIT_EDGE | armed, waiting for a rising edge of the synchronised signal
// S_MEASURE   | signal high, prescaler chain and unit counter running
module pulse_width_meter #(
   parameter int CNT1US = 108,
   parameter int CNT1MS = 1000,
   parameter int CNT1S  = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_sig_in,
   input  logic        i_arm,
   input  logic        i_abort,
   input  logic [1:0]  i_tunit,
   output logic [15:0] o_meas_len,
   output logic        o_meas_valid,
   output logic        o_meas_ovf,
   output logic        o_busy
);

   localparam int W_US = (CNT1US > 1) ? $clog2(CNT1US) : 1;
   localparam int W_MS = (CNT1MS > 1) ? $clog2(CNT1MS) : 1;
   localparam int W_S  = (CNT1S  > 1) ? $clog2(CNT1S)  : 1;
   localparam logic [W_US-1:0] US_TC = W_US'(CNT1US - 1);
   localparam logic [W_MS-1:0] MS_TC = W_MS'(CNT1MS - 1);
   localparam logic [W_S-1:0]  S_TC  = W_S'(CNT1S - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_EDGE = 2'd1,
      S_MEASURE   = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic r_sync1, r_sync2, r_sig_d;
   logic [1:0] r_unit;
   logic [W_US-1:0] r_pre_us;
   logic [W_MS-1:0] r_pre_ms;
   logic [W_S-1:0]  r_pre_s;
   logic [15:0] r_unit_cnt;
   logic r_ovf;

   logic w_rise;
   logic w_start, w_count, w_done, w_clear, w_latch_unit;
   logic [W_US-1:0] w_us_base;
   logic [W_MS-1:0] w_ms_base;
   logic [W_S-1:0]  w_s_base;
   logic [15:0] w_unit_base;
   logic w_ovf_base;
   logic w_tick_us, w_tick_ms, w_tick_s, w_unit_tick;

   assign w_rise = r_sync2 & ~r_sig_d;
   assign o_busy = (r_state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sig_d <= 1'b0;
      end else begin
         r_sync1 <= i_sig_in;
         r_sync2 <= r_sync1;
         r_sig_d <= r_sync2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_start      = 1'b0;
      w_count      = 1'b0;
      w_done       = 1'b0;
      w_clear      = 1'b0;
      w_latch_unit = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_abort) begin
               w_clear = 1'b1;
            end else if (i_arm && (i_tunit != 2'b11)) begin
               w_latch_unit = 1'b1;
               w_state_nxt  = S_WAIT_EDGE;
            end
         end
         S_WAIT_EDGE: begin
            if (i_abort) begin
               w_clear     = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (w_rise) begin
               // the rising-edge cycle is already high cycle 1
               w_start     = 1'b1;
               w_count     = 1'b1;
               w_state_nxt = S_MEASURE;
            end
         end
         S_MEASURE: begin
            if (i_abort) begin
               w_clear     = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_sync2) begin
               w_count = 1'b1;
            end else begin
               w_done = 1'b1;
`ifdef PULSE_WIDTH_METER_CONT_EN
               w_state_nxt = S_WAIT_EDGE;
`else
               w_state_nxt = S_IDLE;
`endif
            end
         end
         default: begin
            w_clear     = 1'b1;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // On the starting cycle the chain behaves as if freshly cleared, then counts once.
   always_comb begin
      w_us_base   = w_start ? US_TC : r_pre_us;
      w_ms_base   = w_start ? MS_TC : r_pre_ms;
      w_s_base    = w_start ? S_TC  : r_pre_s;
      w_unit_base = w_start ? 16'd0 : r_unit_cnt;
      w_ovf_base  = w_start ? 1'b0  : r_ovf;
      w_tick_us   = w_count   && (w_us_base == '0);
      w_tick_ms   = w_tick_us && (w_ms_base == '0);
      w_tick_s    = w_tick_ms && (w_s_base == '0);
      case (r_unit)
         2'b00:   w_unit_tick = w_tick_us;
         2'b01:   w_unit_tick = w_tick_ms;
         2'b10:   w_unit_tick = w_tick_s;
         default: w_unit_tick = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_unit     <= 2'b00;
         r_pre_us   <= '0;
         r_pre_ms   <= '0;
         r_pre_s    <= '0;
         r_unit_cnt <= 16'd0;
         r_ovf      <= 1'b0;
      end else begin
         if (w_latch_unit) r_unit <= i_tunit;
         if (w_clear) begin
            r_pre_us   <= '0;
            r_pre_ms   <= '0;
            r_pre_s    <= '0;
            r_unit_cnt <= 16'd0;
            r_ovf      <= 1'b0;
         end else if (w_count) begin
            r_pre_us <= w_tick_us ? US_TC : (w_us_base - W_US'(1));
            if (w_tick_us) r_pre_ms <= w_tick_ms ? MS_TC : (w_ms_base - W_MS'(1));
            else           r_pre_ms <= w_ms_base;
            if (w_tick_ms) r_pre_s <= w_tick_s ? S_TC : (w_s_base - W_S'(1));
            else           r_pre_s <= w_s_base;
            if (w_unit_tick && (w_unit_base == 16'hFFFF)) begin
               r_unit_cnt <= 16'hFFFF;
               r_ovf      <= 1'b1;
            end else if (w_unit_tick) begin
               r_unit_cnt <= w_unit_base + 16'd1;
               r_ovf      <= w_ovf_base;
            end else begin
               r_unit_cnt <= w_unit_base;
               r_ovf      <= w_ovf_base;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_meas_valid <= 1'b0;
         o_meas_len   <= 16'd0;
         o_meas_ovf   <= 1'b0;
      end else begin
         o_meas_valid <= w_done;
         if (w_done) begin
            o_meas_len <= r_unit_cnt;
            o_meas_ovf <= r_ovf;
         end
      end
   end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Scoreboard bench for pulse_width_meter: two instances (CNT1US=4 and CNT1US=1),
// expected results queued at stimulus time and popped by per-instance monitors on each strobe.
module tb_pulse_width_meter;

`ifdef PULSE_WIDTH_METER_CONT_EN
   localparam logic BUSY_AFTER = 1'b1;
`else
   localparam logic BUSY_AFTER = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic sig, arm, abort;
   logic [1:0] tunit;
   logic [15:0] len;
   logic valid, ovf, busy;

   logic sig2, arm2, abort2;
   logic [1:0] tunit2;
   logic [15:0] len2;
   logic valid2, ovf2, busy2;

   int n_pass = 0;
   int n_total = 0;
   logic [17:0] q1[$];
   logic [17:0] q2[$];
   logic [17:0] e1, e2;
   logic [15:0] last_len;
   logic last_ovf;

   pulse_width_meter #(.CNT1US(4), .CNT1MS(3), .CNT1S(2)) dut (
      .clk(clk), .rst_n(rst_n), .i_sig_in(sig), .i_arm(arm), .i_abort(abort),
      .i_tunit(tunit), .o_meas_len(len), .o_meas_valid(valid), .o_meas_ovf(ovf),
      .o_busy(busy)
   );

   pulse_width_meter #(.CNT1US(1), .CNT1MS(3), .CNT1S(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .i_sig_in(sig2), .i_arm(arm2), .i_abort(abort2),
      .i_tunit(tunit2), .o_meas_len(len2), .o_meas_valid(valid2), .o_meas_ovf(ovf2),
      .o_busy(busy2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n && valid) begin
         if (q1.size() == 0) begin
            n_total++;
            $display("FAIL dut1 unexpected strobe: got len=%0d ovf=%0d expected no strobe", len, ovf);
         end else begin
            e1 = q1.pop_front();
            check("dut1 meas_len", {16'd0, len}, {16'd0, e1[15:0]});
            check("dut1 meas_ovf", {31'd0, ovf}, {31'd0, e1[16]});
            check("dut1 busy at strobe", {31'd0, busy}, {31'd0, e1[17]});
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && valid2) begin
         if (q2.size() == 0) begin
            n_total++;
            $display("FAIL dut2 unexpected strobe: got len=%0d ovf=%0d expected no strobe", len2, ovf2);
         end else begin
            e2 = q2.pop_front();
            check("dut2 meas_len", {16'd0, len2}, {16'd0, e2[15:0]});
            check("dut2 meas_ovf", {31'd0, ovf2}, {31'd0, e2[16]});
            check("dut2 busy at strobe", {31'd0, busy2}, {31'd0, e2[17]});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic arm1(input logic [1:0] u);
      tunit = u; arm = 1'b1; tick(1); arm = 1'b0;
   endtask

   task automatic pulse1(input int n);
      sig = 1'b1; tick(n); sig = 1'b0; tick(6);
   endtask

   task automatic expect1(input logic [15:0] l, input logic o);
      q1.push_back({BUSY_AFTER, o, l});
      last_len = l; last_ovf = o;
   endtask

   task automatic abort1();
      abort = 1'b1; tick(1); abort = 1'b0; tick(1);
   endtask

   task automatic arm2_t(input logic [1:0] u);
      tunit2 = u; arm2 = 1'b1; tick(1); arm2 = 1'b0;
   endtask

   task automatic pulse2(input int n);
      sig2 = 1'b1; tick(n); sig2 = 1'b0; tick(6);
   endtask

   task automatic abort2_t();
      abort2 = 1'b1; tick(1); abort2 = 1'b0; tick(1);
   endtask

   initial begin
      rst_n = 1'b0;
      sig = 1'b0; arm = 1'b0; abort = 1'b0; tunit = 2'b00;
      sig2 = 1'b0; arm2 = 1'b0; abort2 = 1'b0; tunit2 = 2'b00;
      last_len = 16'd0; last_ovf = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(2);
      check("reset meas_len", {16'd0, len}, 32'd0);
      check("reset meas_valid", {31'd0, valid}, 32'd0);
      check("reset meas_ovf", {31'd0, ovf}, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset dut2 busy", {31'd0, busy2}, 32'd0);

      // saturation then recovery on the CNT1US=1 instance
      arm2_t(2'b00);
      q2.push_back({BUSY_AFTER, 1'b1, 16'hFFFF});
      pulse2(70000);
      abort2_t();
      arm2_t(2'b00);
      q2.push_back({BUSY_AFTER, 1'b0, 16'd5});
      pulse2(5);
      abort2_t();

      // 10 cycles / 4 = 2 us
      arm1(2'b00);
      check("busy after arm", {31'd0, busy}, 32'd1);
      expect1(16'd2, 1'b0);
      pulse1(10);
      abort1();

      // 25 / 12 = 2 ms, 50 / 24 = 2 s
      arm1(2'b01);
      expect1(16'd2, 1'b0);
      pulse1(25);
      abort1();
      arm1(2'b10);
      expect1(16'd2, 1'b0);
      pulse1(50);
      abort1();

      // armed while already high: partial pulse ignored, next 9-cycle pulse gives 2
      sig = 1'b1; tick(3);
      arm1(2'b00);
      tick(17);
      sig = 1'b0; tick(6);
      check("busy waiting after partial", {31'd0, busy}, 32'd1);
      expect1(16'd2, 1'b0);
      pulse1(9);
      abort1();

      // re-arm and tunit change while busy are ignored: unit stays us
      arm1(2'b00);
      tick(2);
      tunit = 2'b01; arm = 1'b1; tick(1); arm = 1'b0;
      expect1(16'd2, 1'b0);
      pulse1(10);
      abort1();

      // zero-unit and exact-unit boundaries
      arm1(2'b00);
      expect1(16'd0, 1'b0);
      pulse1(3);
      abort1();
      arm1(2'b00);
      expect1(16'd1, 1'b0);
      pulse1(4);
      abort1();

      // abort mid-pulse: no strobe, previous result held
      arm1(2'b00);
      sig = 1'b1; tick(7);
      abort = 1'b1; tick(1); abort = 1'b0;
      check("busy after abort", {31'd0, busy}, 32'd0);
      tick(13);
      sig = 1'b0; tick(6);
      check("len held after abort", {16'd0, len}, {16'd0, last_len});
      check("ovf held after abort", {31'd0, ovf}, {31'd0, last_ovf});

      // reserved unit ignored
      arm1(2'b11);
      tick(1);
      check("busy after tunit=11", {31'd0, busy}, 32'd0);
      pulse1(10);

      // arm and abort together: abort wins
      tunit = 2'b00; arm = 1'b1; abort = 1'b1; tick(1); arm = 1'b0; abort = 1'b0;
      check("busy after arm+abort", {31'd0, busy}, 32'd0);

      // single arm, three pulses
      arm1(2'b00);
`ifdef PULSE_WIDTH_METER_CONT_EN
      expect1(16'd2, 1'b0);
      expect1(16'd3, 1'b0);
      expect1(16'd0, 1'b0);
`else
      expect1(16'd2, 1'b0);
`endif
      pulse1(8);
      pulse1(12);
      pulse1(3);
      check("busy after three pulses", {31'd0, busy}, {31'd0, BUSY_AFTER});
      abort1();

      // reset in the middle of a pulse
      arm1(2'b00);
      sig = 1'b1; tick(8);
      rst_n = 1'b0; #1;
      check("mid-reset meas_len", {16'd0, len}, 32'd0);
      check("mid-reset meas_valid", {31'd0, valid}, 32'd0);
      check("mid-reset meas_ovf", {31'd0, ovf}, 32'd0);
      check("mid-reset busy", {31'd0, busy}, 32'd0);
      tick(2);
      sig = 1'b0;
      rst_n = 1'b1;
      tick(6);
      check("busy after reset release", {31'd0, busy}, 32'd0);

      tick(5);
      check("dut1 pending results", q1.size(), 32'd0);
      check("dut2 pending results", q2.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
